turn_referee: RTL

//  Source side of the light-chain control interface. Conditions the raw player

---
 rtl/game_pkg.sv | 28 ++
 rtl/turn_referee_key_edge_sync.sv | 33 +++
 rtl/turn_referee.sv | 128 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// game_pkg: types shared by the turn referee and the light cells.
//  turn_t      - encoding of whose turn it is on the chain's turn[1:0] bus
//  ref_state_t - referee FSM states (exposed on the referee's state output)
//  turn_of()   - turn bus value shown while the referee is in a given state
package game_pkg;

   typedef enum logic [1:0] {
      TURN_NONE  = 2'b00,
      TURN_GREEN = 2'b01,
      TURN_RED   = 2'b10
   } turn_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RED,
      ST_GREEN,
      ST_CLEAR
   } ref_state_t;

   function automatic turn_t turn_of(input ref_state_t s);
      case (s)
         ST_RED:   return TURN_RED;
         ST_GREEN: return TURN_GREEN;
         default:  return TURN_NONE;
      endcase
   endfunction

endpackage

// File: rtl/turn_referee_key_edge_sync.sv
// key_edge_sync: brings one raw asynchronous key into the clock domain and
// turns it into a single-cycle press strobe on its rising edge.
//  clock  in   system clock
//  reset  in   synchronous, active-low reset
//  raw    in   raw key level, asynchronous, active-high
//  press  out  high for one cycle per key press (held key -> one press)
// A raw high first sampled at edge N shows as press in the cycle after N+1.
module key_edge_sync (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic press
);

   logic sync1;
   logic sync2;
   logic prev;

   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign press = sync2 & ~prev;

endmodule

// File: rtl/turn_referee.sv
// turn_referee: source side of the light-chain control interface.
// Conditions the three player keys, alternates red/green turns with a
// per-turn timeout and drives the chain's turn bus, clear (RK) and advance (LK).
//  clock       in   system clock, rising edge
//  reset       in   synchronous, active-low reset
//  key_red     in   raw red-player key
//  key_green   in   raw green-player key
//  key_clear   in   raw clear/start key
//  turn        out  10 red turn, 01 green turn, 00 none
//  RK          out  one-cycle clear pulse
//  LK          out  one-cycle advance pulse (one per accepted move)
//  foul        out  one-cycle pulse when the off-turn player presses
//  move_count  out  accepted moves since the last clear, saturating
//  state       out  current referee state, for observation
// Chain handshake: RK and LK are single-cycle strobes with no back-pressure;
// every light cell must act on each cycle either one is high. turn is a level.
module turn_referee
   import game_pkg::*;
#(
   parameter int unsigned TURN_TIMEOUT = 50_000_000,
   parameter int unsigned CNT_W        = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             key_red,
   input  logic             key_green,
   input  logic             key_clear,
   output logic [1:0]       turn,
   output logic             RK,
   output logic             LK,
   output logic             foul,
   output logic [CNT_W-1:0] move_count,
   output ref_state_t       state
);

   localparam int unsigned TIMER_W = (TURN_TIMEOUT > 2) ? $clog2(TURN_TIMEOUT) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TURN_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

   logic red_p;
   logic green_p;
   logic clear_p;

   key_edge_sync u_sync_red   (.clock(clock), .reset(reset), .raw(key_red),   .press(red_p));
   key_edge_sync u_sync_green (.clock(clock), .reset(reset), .raw(key_green), .press(green_p));
   key_edge_sync u_sync_clear (.clock(clock), .reset(reset), .raw(key_clear), .press(clear_p));

   ref_state_t         state_q, state_nxt;
   logic [TIMER_W-1:0] timer_q, timer_nxt;
   logic [CNT_W-1:0]   count_q, count_nxt;
   logic               lk_nxt, rk_nxt, foul_nxt;
   turn_t              turn_q;

   // Move handling is shared by both colours: "own" is the player whose turn
   // it is, "other" is the opponent.
   logic own_p;
   logic other_p;

   always_comb begin
      own_p   = (state_q == ST_GREEN) ? green_p : red_p;
      other_p = (state_q == ST_GREEN) ? red_p   : green_p;

      state_nxt = state_q;
      timer_nxt = timer_q;
      count_nxt = count_q;
      lk_nxt    = 1'b0;
      rk_nxt    = 1'b0;
      foul_nxt  = 1'b0;

      // A clear press wins over everything else; while already clearing it is
      // absorbed so a single clear never produces two RK pulses.
      if (clear_p && state_q != ST_CLEAR) begin
         state_nxt = ST_CLEAR;
         rk_nxt    = 1'b1;
         count_nxt = '0;
         timer_nxt = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               timer_nxt = '0;
               if (red_p) state_nxt = ST_RED;
            end
            ST_RED, ST_GREEN: begin
               foul_nxt  = other_p;
               timer_nxt = timer_q + 1'b1;
               if (own_p || timer_q == TIMER_LAST) begin
                  state_nxt = (state_q == ST_RED) ? ST_GREEN : ST_RED;
                  timer_nxt = '0;
               end
               if (own_p) begin
                  lk_nxt = 1'b1;
                  if (count_q != CNT_MAX) count_nxt = count_q + 1'b1;
               end
            end
            ST_CLEAR: begin
               state_nxt = ST_IDLE;
               timer_nxt = '0;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         count_q <= '0;
         turn_q  <= TURN_NONE;
         LK      <= 1'b0;
         RK      <= 1'b0;
         foul    <= 1'b0;
      end else begin
         state_q <= state_nxt;
         timer_q <= timer_nxt;
         count_q <= count_nxt;
         turn_q  <= turn_of(state_nxt);
         LK      <= lk_nxt;
         RK      <= rk_nxt;
         foul    <= foul_nxt;
      end
   end

   assign turn       = turn_q;
   assign move_count = count_q;
   assign state      = state_q;

endmodule
